// File: rtl/circ_therm_mask.sv
// Head/tail/count tracker for an N-entry circular queue with registered,
// wrap-aware occupancy mask and a combinational "older than query" mask.
module circ_therm_mask #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic [$clog2(W+1)-1:0] i_alloc_cnt,
    input  logic [$clog2(W+1)-1:0] i_retire_cnt,
    input  logic [N-1:0]           i_query_oh,
    output logic [$clog2(W+1)-1:0] o_alloc_grant,
    output logic [$clog2(W+1)-1:0] o_retire_grant,
    output logic [N-1:0]           o_head_oh,
    output logic [N-1:0]           o_tail_oh,
    output logic [N-1:0]           o_valid_mask,
    output logic [N-1:0]           o_older_mask,
    output logic [$clog2(N+1)-1:0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int CW = $clog2(W+1);
    localparam int NW = $clog2(N+1);
    localparam int PW = $clog2(N);

    // Bit gb of every entry index, used to encode a one-hot without a priority chain.
    function automatic logic [N-1:0] bit_sel(input int b);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [NW-1:0] r_count;
    logic [N-1:0]  r_head_oh;
    logic [N-1:0]  r_tail_oh;
    logic [N-1:0]  r_valid_mask;
    logic          r_full;
    logic          r_empty;

    logic [NW-1:0] w_free;
    logic [NW-1:0] w_alloc_req;
    logic [NW-1:0] w_retire_req;
    logic [NW-1:0] w_ag;
    logic [NW-1:0] w_rg;
    logic [NW-1:0] w_head_sum;
    logic [NW-1:0] w_tail_sum;
    logic [PW-1:0] w_head_next;
    logic [PW-1:0] w_tail_next;
    logic [NW-1:0] w_count_next;
    logic [N-1:0]  w_ge_hn;
    logic [N-1:0]  w_ge_tn;
    logic [N-1:0]  w_head_oh_next;
    logic [N-1:0]  w_tail_oh_next;
    logic [N-1:0]  w_valid_next;
    logic [PW-1:0] w_q_idx;
    logic [N-1:0]  w_ge_rh;
    logic [N-1:0]  w_ge_q;
    logic [N-1:0]  w_range_q;

    assign w_free       = NW'(N) - r_count;
    assign w_alloc_req  = NW'(i_alloc_cnt);
    assign w_retire_req = NW'(i_retire_cnt);

    // Both grants use the start-of-cycle count, so a slot freed this cycle is not reused.
    assign w_rg = i_flush ? '0 : ((w_retire_req < r_count) ? w_retire_req : r_count);
    assign w_ag = i_flush ? '0 : ((w_alloc_req < w_free) ? w_alloc_req : w_free);

    assign o_retire_grant = CW'(w_rg);
    assign o_alloc_grant  = CW'(w_ag);

    assign w_head_sum   = NW'(r_head) + w_rg;
    assign w_tail_sum   = NW'(r_tail) + w_ag;
    assign w_head_next  = i_flush ? '0 : w_head_sum[PW-1:0];
    assign w_tail_next  = i_flush ? '0 : w_tail_sum[PW-1:0];
    assign w_count_next = i_flush ? '0 : (r_count - w_rg + w_ag);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_therm
            assign w_ge_hn[gi]        = (PW'(gi) >= w_head_next);
            assign w_ge_tn[gi]        = (PW'(gi) >= w_tail_next);
            assign w_head_oh_next[gi] = (PW'(gi) == w_head_next);
            assign w_tail_oh_next[gi] = (PW'(gi) == w_tail_next);
            assign w_ge_rh[gi]        = (PW'(gi) >= r_head);
            assign w_ge_q[gi]         = (PW'(gi) >= w_q_idx);
        end
        for (genvar gb = 0; gb < PW; gb++) begin : g_qenc
            localparam logic [N-1:0] SEL = bit_sel(gb);
            assign w_q_idx[gb] = |(i_query_oh & SEL);
        end
    endgenerate

    // head == tail is ambiguous; the count decides between empty and full.
    always_comb begin
        w_valid_next = '0;
        if (w_count_next == NW'(N)) begin
            w_valid_next = '1;
        end else if (w_count_next == '0) begin
            w_valid_next = '0;
        end else if (w_tail_next > w_head_next) begin
            w_valid_next = w_ge_hn & ~w_ge_tn;
        end else begin
            w_valid_next = w_ge_hn | ~w_ge_tn;
        end
    end

    always_comb begin
        w_range_q = '0;
        if (w_q_idx > r_head) begin
            w_range_q = w_ge_rh & ~w_ge_q;
        end else if (w_q_idx < r_head) begin
            w_range_q = w_ge_rh | ~w_ge_q;
        end
    end

    assign o_older_mask = r_valid_mask & w_range_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_head_oh    <= N'(1);
            r_tail_oh    <= N'(1);
            r_valid_mask <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
        end else begin
            r_head       <= w_head_next;
            r_tail       <= w_tail_next;
            r_count      <= w_count_next;
            r_head_oh    <= w_head_oh_next;
            r_tail_oh    <= w_tail_oh_next;
            r_valid_mask <= w_valid_next;
            r_full       <= (w_count_next == NW'(N));
            r_empty      <= (w_count_next == '0);
        end
    end

    assign o_head_oh    = r_head_oh;
    assign o_tail_oh    = r_tail_oh;
    assign o_valid_mask = r_valid_mask;
    assign o_count      = r_count;
    assign o_full       = r_full;
    assign o_empty      = r_empty;

endmodule

// File: tb/tb_circ_therm_mask.sv
// Table-driven bench for circ_therm_mask (N=8, W=2) with a post-edge scoreboard
// plus hand-written flush and asynchronous-reset sequences.
module tb_circ_therm_mask;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] alloc_cnt;
    logic [1:0] retire_cnt;
    logic [7:0] query_oh;
    logic [1:0] alloc_grant;
    logic [1:0] retire_grant;
    logic [7:0] head_oh;
    logic [7:0] tail_oh;
    logic [7:0] valid_mask;
    logic [7:0] older_mask;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    circ_therm_mask #(.N(8), .W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_alloc_cnt(alloc_cnt), .i_retire_cnt(retire_cnt), .i_query_oh(query_oh),
        .o_alloc_grant(alloc_grant), .o_retire_grant(retire_grant),
        .o_head_oh(head_oh), .o_tail_oh(tail_oh), .o_valid_mask(valid_mask),
        .o_older_mask(older_mask), .o_count(count), .o_full(full), .o_empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ac;
        logic [1:0] rc;
        logic [7:0] q;
        logic [1:0] eag;
        logic [1:0] erg;
        logic [7:0] eh;
        logic [7:0] et;
        logic [7:0] ev;
        logic [7:0] eo;
        logic [3:0] ec;
    } vec_t;

    typedef struct {
        logic [7:0] eh;
        logic [7:0] et;
        logic [7:0] ev;
        logic [7:0] eo;
        logic [3:0] ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic [1:0] ac, logic [1:0] rc, logic [7:0] q,
                                logic [1:0] eag, logic [1:0] erg, logic [7:0] eh,
                                logic [7:0] et, logic [7:0] ev, logic [7:0] eo,
                                logic [3:0] ec);
        vec_t v;
        v.ac = ac; v.rc = rc; v.q = q; v.eag = eag; v.erg = erg;
        v.eh = eh; v.et = et; v.ev = ev; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, " head_oh"}, 32'(head_oh), 32'(e.eh));
        chk({tag, " tail_oh"}, 32'(tail_oh), 32'(e.et));
        chk({tag, " valid_mask"}, 32'(valid_mask), 32'(e.ev));
        chk({tag, " older_mask"}, 32'(older_mask), 32'(e.eo));
        chk({tag, " count"}, 32'(count), 32'(e.ec));
        chk({tag, " full"}, 32'(full), 32'(e.ec == 4'd8));
        chk({tag, " empty"}, 32'(empty), 32'(e.ec == 4'd0));
    endtask

    initial begin
        exp_t e;
        //            ac    rc    q      ag    rg    head   tail   valid  older  cnt
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd2, 2'd0, 8'h01, 8'h04, 8'h03, 8'h00, 4'd2));
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd2, 2'd0, 8'h01, 8'h10, 8'h0F, 8'h00, 4'd4));
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd2, 2'd0, 8'h01, 8'h40, 8'h3F, 8'h00, 4'd6));
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd2, 2'd0, 8'h01, 8'h01, 8'hFF, 8'h00, 4'd8));
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd0, 2'd0, 8'h01, 8'h01, 8'hFF, 8'h00, 4'd8));
        vecs.push_back(mk(2'd2, 2'd2, 8'h01, 2'd0, 2'd2, 8'h04, 8'h01, 8'hFC, 8'hFC, 4'd6));
        vecs.push_back(mk(2'd2, 2'd2, 8'h01, 2'd2, 2'd2, 8'h10, 8'h04, 8'hF3, 8'hF0, 4'd6));
        vecs.push_back(mk(2'd0, 2'd2, 8'h02, 2'd0, 2'd2, 8'h40, 8'h04, 8'hC3, 8'hC1, 4'd4));
        vecs.push_back(mk(2'd0, 2'd2, 8'h01, 2'd0, 2'd2, 8'h01, 8'h04, 8'h03, 8'h00, 4'd2));
        vecs.push_back(mk(2'd0, 2'd2, 8'h01, 2'd0, 2'd2, 8'h04, 8'h04, 8'h00, 8'h00, 4'd0));
        vecs.push_back(mk(2'd2, 2'd2, 8'h01, 2'd2, 2'd0, 8'h04, 8'h10, 8'h0C, 8'h0C, 4'd2));
        vecs.push_back(mk(2'd0, 2'd2, 8'h01, 2'd0, 2'd2, 8'h10, 8'h10, 8'h00, 8'h00, 4'd0));
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd2, 2'd0, 8'h10, 8'h40, 8'h30, 8'h30, 4'd2));
        vecs.push_back(mk(2'd0, 2'd2, 8'h01, 2'd0, 2'd2, 8'h40, 8'h40, 8'h00, 8'h00, 4'd0));
        vecs.push_back(mk(2'd2, 2'd0, 8'h01, 2'd2, 2'd0, 8'h40, 8'h01, 8'hC0, 8'hC0, 4'd2));
        vecs.push_back(mk(2'd2, 2'd0, 8'h02, 2'd2, 2'd0, 8'h40, 8'h04, 8'hC3, 8'hC1, 4'd4));
        vecs.push_back(mk(2'd0, 2'd0, 8'h40, 2'd0, 2'd0, 8'h40, 8'h04, 8'hC3, 8'h00, 4'd4));
        vecs.push_back(mk(2'd0, 2'd0, 8'h08, 2'd0, 2'd0, 8'h40, 8'h04, 8'hC3, 8'hC3, 4'd4));
        vecs.push_back(mk(2'd0, 2'd2, 8'h01, 2'd0, 2'd2, 8'h01, 8'h04, 8'h03, 8'h00, 4'd2));

        rst_n = 1'b0; flush = 1'b0; alloc_cnt = '0; retire_cnt = '0; query_oh = 8'h01;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        e.eh = 8'h01; e.et = 8'h01; e.ev = 8'h00; e.eo = 8'h00; e.ec = 4'd0;
        chk_state("reset", e);
        chk("reset retire_grant", 32'(retire_grant), 32'd0);
        $display("reset: head_oh=%h tail_oh=%h valid=%h count=%0d", head_oh, tail_oh, valid_mask, count);

        foreach (vecs[i]) begin
            alloc_cnt = vecs[i].ac; retire_cnt = vecs[i].rc; query_oh = vecs[i].q;
            #1;
            chk($sformatf("vec%0d alloc_grant", i), 32'(alloc_grant), 32'(vecs[i].eag));
            chk($sformatf("vec%0d retire_grant", i), 32'(retire_grant), 32'(vecs[i].erg));
            e.eh = vecs[i].eh; e.et = vecs[i].et; e.ev = vecs[i].ev;
            e.eo = vecs[i].eo; e.ec = vecs[i].ec;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk_state($sformatf("vec%0d", i), e);
            $display("vec %0d: ac=%0d rc=%0d ag=%0d rg=%0d head_oh=%h tail_oh=%h valid=%h older=%h count=%0d",
                     i, vecs[i].ac, vecs[i].rc, vecs[i].eag, vecs[i].erg,
                     head_oh, tail_oh, valid_mask, older_mask, count);
        end

        // Flush in the same cycle as an allocation request.
        alloc_cnt = 2'd2; retire_cnt = 2'd1; flush = 1'b1; query_oh = 8'h01;
        #1;
        chk("flush alloc_grant", 32'(alloc_grant), 32'd0);
        chk("flush retire_grant", 32'(retire_grant), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; retire_cnt = 2'd0;
        e.eh = 8'h01; e.et = 8'h01; e.ev = 8'h00; e.eo = 8'h00; e.ec = 4'd0;
        chk_state("flush", e);
        $display("flush: head_oh=%h tail_oh=%h count=%0d empty=%0d", head_oh, tail_oh, count, empty);

        // Asynchronous reset mid-allocation, between clock edges.
        #1;
        chk("prealloc alloc_grant", 32'(alloc_grant), 32'd2);
        @(posedge clk); #1;
        chk("prealloc count", 32'(count), 32'd2);
        retire_cnt = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        e.eh = 8'h01; e.et = 8'h01; e.ev = 8'h00; e.eo = 8'h00; e.ec = 4'd0;
        chk_state("async_reset", e);
        chk("async_reset retire_grant", 32'(retire_grant), 32'd0);
        chk("async_reset alloc_grant", 32'(alloc_grant), 32'd2);
        $display("async reset: head_oh=%h tail_oh=%h valid=%h count=%0d rg=%0d",
                 head_oh, tail_oh, valid_mask, count, retire_grant);
        @(posedge clk); #1;
        rst_n = 1'b1; alloc_cnt = '0; retire_cnt = '0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
